// File: rtl/tag_line_decoder_if.sv
// tag_line_decoder_if
//   Request handshake and line-strobe bundle for the lease cache tag store
//   write-side decoder.
//   slave  (decoder side): takes req_vld/req_op/req_idx and drives req_rdy,
//          line_we, line_we_vld, line_we_idx, resident, busy and err.
//   master (requester/tag-array side): the mirror image.
interface tag_line_decoder_if #(
    parameter int N_LINES = 1024,
    parameter int W_IDX   = 10
);
    logic               req_vld;
    logic               req_rdy;
    logic [1:0]         req_op;
    logic [W_IDX-1:0]   req_idx;
    logic [N_LINES-1:0] line_we;
    logic               line_we_vld;
    logic [W_IDX-1:0]   line_we_idx;
    logic [N_LINES-1:0] resident;
    logic               busy;
    logic               err;

    modport master (
        output req_vld, req_op, req_idx,
        input  req_rdy, line_we, line_we_vld, line_we_idx, resident, busy, err
    );

    modport slave (
        input  req_vld, req_op, req_idx,
        output req_rdy, line_we, line_we_vld, line_we_idx, resident, busy, err
    );
endinterface

// File: rtl/tag_line_decoder.sv
// tag_line_decoder
//   Binary-to-one-hot line decoder for the lease cache tag store. Accepts a
//   line index + op (NOP/ALLOC/INVAL/FLUSH) over a valid/ready handshake,
//   drives a registered one-hot tag-array write strobe two edges after
//   acceptance, keeps the per-line resident bitmap and sequences whole-cache
//   flushes (drain the pipeline, then sweep every line once).
//
// Ports
//   i_clk  : clock, all state on the rising edge
//   i_rst  : asynchronous active-high reset
//   bus    : tag_line_decoder_if.slave (request handshake, line strobe,
//            resident bitmap, busy, err)
//
// Optional feature macro: TAG_LINE_DECODER_CHECK_EN
//   defined   -> err flags ALLOC of a resident line / INVAL of an absent line
//                (sticky until reset, op still executes)
//   undefined -> err tied to 0
//
// state  | meaning
// IDLE   | accepting requests
// DRAIN  | flush accepted, waiting for in-flight requests to leave the pipe
// SWEEP  | strobing and clearing line fidx, one line per cycle
module tag_line_decoder #(
    parameter int N_LINES = 1024,
    parameter int W_IDX   = 10
) (
    input  logic               i_clk,
    input  logic               i_rst,
    tag_line_decoder_if.slave  bus
);
    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_ALLOC = 2'b01;
    localparam logic [1:0] OP_INVAL = 2'b10;
    localparam logic [1:0] OP_FLUSH = 2'b11;

    // Bits of the index below the two radix-4 levels resolved by the sub-decode.
    localparam int               W_LO     = W_IDX - 4;
    localparam logic [W_IDX-1:0] LO_MASK  = W_IDX'((1 << W_LO) - 1);
    localparam logic [W_IDX-1:0] LAST_IDX = W_IDX'(N_LINES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_SWEEP} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W_IDX-1:0]   r_fidx;

    logic               r_s1_vld;
    logic [1:0]         r_s1_op;
    logic [W_IDX-1:0]   r_s1_idx;
    logic [3:0]         r_s1_grp;

    logic               r_s2_vld;
    logic [1:0]         r_s2_op;
    logic [W_IDX-1:0]   r_s2_idx;
    logic [15:0]        r_s2_sub;

    logic [N_LINES-1:0] r_line_we;
    logic               r_line_we_vld;
    logic [W_IDX-1:0]   r_line_we_idx;
    logic [N_LINES-1:0] r_resident;

    logic               w_busy;
    logic               w_acc;
    logic               w_sweep_last;
    logic               w_s2_strobe;
    logic [3:0]         w_grp;
    logic [15:0]        w_sub;
    logic [N_LINES-1:0] w_dec;
    logic [N_LINES-1:0] w_fdec;

    assign w_busy       = (r_state != ST_IDLE);
    assign w_acc        = bus.req_vld & ~w_busy;
    assign w_sweep_last = (r_fidx == LAST_IDX);
    assign w_s2_strobe  = r_s2_vld & ((r_s2_op == OP_ALLOC) | (r_s2_op == OP_INVAL));

    // Radix-4 hierarchy: top 2 bits -> 4 groups, next 2 bits -> 16 sub-groups,
    // remaining low bits resolved in the final expansion.
    assign w_grp = 4'b0001 << bus.req_idx[W_IDX-1 -: 2];

    for (genvar j = 0; j < 16; j++) begin : g_sub
        assign w_sub[j] = r_s1_grp[j / 4] & (r_s1_idx[W_IDX-3 -: 2] == 2'(j % 4));
    end

    for (genvar i = 0; i < N_LINES; i++) begin : g_dec
        assign w_dec[i] = r_s2_sub[i >> W_LO] &
                          ((r_s2_idx & LO_MASK) == (W_IDX'(i) & LO_MASK));
    end

    assign w_fdec = {{(N_LINES-1){1'b0}}, 1'b1} << r_fidx;

    // FLUSH itself occupies a (non-strobing) pipeline slot, so DRAIN always
    // lasts two cycles: leaving when stage 1 is empty lets stage 2 retire on
    // the same edge the sweep starts.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_acc && (bus.req_op == OP_FLUSH)) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!r_s1_vld) w_state_nxt = ST_SWEEP;
            ST_SWEEP: if (w_sweep_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_fidx        <= '0;
            r_s1_vld      <= 1'b0;
            r_s1_op       <= OP_NOP;
            r_s1_idx      <= '0;
            r_s1_grp      <= '0;
            r_s2_vld      <= 1'b0;
            r_s2_op       <= OP_NOP;
            r_s2_idx      <= '0;
            r_s2_sub      <= '0;
            r_line_we     <= '0;
            r_line_we_vld <= 1'b0;
            r_line_we_idx <= '0;
            r_resident    <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state != ST_SWEEP) begin
                r_fidx <= '0;
            end else if (!w_sweep_last) begin
                r_fidx <= r_fidx + 1'b1;
            end

            r_s1_vld <= w_acc;
            if (w_acc) begin
                r_s1_op  <= bus.req_op;
                r_s1_idx <= bus.req_idx;
                r_s1_grp <= w_grp;
            end

            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_op  <= r_s1_op;
                r_s2_idx <= r_s1_idx;
                r_s2_sub <= w_sub;
            end

            // The pipe is empty throughout SWEEP, so the two writers never collide.
            if (r_state == ST_SWEEP) begin
                r_line_we            <= w_fdec;
                r_line_we_vld        <= 1'b1;
                r_line_we_idx        <= r_fidx;
                r_resident[r_fidx]   <= 1'b0;
            end else if (w_s2_strobe) begin
                r_line_we            <= w_dec;
                r_line_we_vld        <= 1'b1;
                r_line_we_idx        <= r_s2_idx;
                r_resident[r_s2_idx] <= (r_s2_op == OP_ALLOC);
            end else begin
                r_line_we            <= '0;
                r_line_we_vld        <= 1'b0;
                r_line_we_idx        <= '0;
            end
        end
    end

`ifdef TAG_LINE_DECODER_CHECK_EN
    logic r_err;
    logic w_err_hit;

    // ALLOC of a resident line or INVAL of an absent line: op matches current bit.
    assign w_err_hit = w_s2_strobe & ((r_s2_op == OP_ALLOC) == r_resident[r_s2_idx]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (w_err_hit) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.req_rdy     = ~w_busy;
    assign bus.busy        = w_busy;
    assign bus.line_we     = r_line_we;
    assign bus.line_we_vld = r_line_we_vld;
    assign bus.line_we_idx = r_line_we_idx;
    assign bus.resident    = r_resident;
endmodule

// File: tb/tb_tag_line_decoder.sv
// tb_tag_line_decoder
//   Scoreboard bench for tag_line_decoder (1024 lines). Expected strobes are
//   queued with their due edge when a request is accepted and compared when
//   that edge arrives; a bench-side resident/err model is updated as items
//   retire. Honours TAG_LINE_DECODER_CHECK_EN for the err expectation.
module tb_tag_line_decoder;
    localparam int NL = 1024;
    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_ALLOC = 2'b01;
    localparam logic [1:0] OP_INVAL = 2'b10;
    localparam logic [1:0] OP_FLUSH = 2'b11;
`ifdef TAG_LINE_DECODER_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct {
        int       due;
        logic [1:0] op;
        int       idx;
        bit       sw;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    int   flush_edge = -1;
    int   busy_cnt = 0;
    bit   mon_en = 1'b0;
    item_t q[$];
    logic [NL-1:0] m_res;
    logic          m_err;

    tag_line_decoder_if #(.N_LINES(NL), .W_IDX(10)) bus ();

    tag_line_decoder #(.N_LINES(NL), .W_IDX(10)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [NL-1:0] obs, input logic [NL-1:0] exp);
        int d;
        n_total++;
        if (obs !== exp) begin
            d = -1;
            for (int b = 0; b < NL; b++) if (d < 0 && obs[b] !== exp[b]) d = b;
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h (low 64 bits, first differing bit %0d)",
                     tag, cyc, obs[63:0], exp[63:0], d);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting
    // rising edge with req_vld still asserted.
    task automatic send(input logic [1:0] op, input int idx, output int acc);
        int n;
        item_t it;
        n = 0;
        acc = -1;
        bus.req_vld = 1'b1;
        bus.req_op  = op;
        bus.req_idx = 10'(idx);
        while (!bus.req_rdy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_rdy) begin
            check("accept_timeout", NL'(0), NL'(1));
            return;
        end
        acc = cyc + 1;
        if (op == OP_FLUSH) begin
            flush_edge = acc;
            for (int k = 0; k < NL; k++) begin
                it.due = acc + 3 + k; it.op = OP_INVAL; it.idx = k; it.sw = 1'b1;
                q.push_back(it);
            end
        end else begin
            it.due = acc + 2; it.op = op; it.idx = idx; it.sw = 1'b0;
            q.push_back(it);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.req_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        logic [NL-1:0] ew;
        bit ev;
        bit eb;
        item_t it;
        #1;
        if (mon_en) begin
            ew = '0;
            ev = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                it = q.pop_front();
                if (it.sw) begin
                    ev = 1'b1;
                    m_res[it.idx] = 1'b0;
                end else if (it.op == OP_ALLOC) begin
                    ev = 1'b1;
                    if (CHK_EN && m_res[it.idx]) m_err = 1'b1;
                    m_res[it.idx] = 1'b1;
                end else if (it.op == OP_INVAL) begin
                    ev = 1'b1;
                    if (CHK_EN && !m_res[it.idx]) m_err = 1'b1;
                    m_res[it.idx] = 1'b0;
                end
                if (ev) ew[it.idx] = 1'b1;
                check("strobe_we", bus.line_we, ew);
                check("strobe_vld", NL'(bus.line_we_vld), NL'(ev));
                if (ev) check("strobe_idx", NL'(bus.line_we_idx), NL'(it.idx));
            end else begin
                check("idle_vld", NL'(bus.line_we_vld), NL'(0));
                check("idle_we", bus.line_we, NL'(0));
            end
            eb = (flush_edge >= 0) && (cyc >= flush_edge) && (cyc < flush_edge + 1026);
            if (bus.busy) busy_cnt++;
            check("busy", NL'(bus.busy), NL'(eb));
            check("req_rdy", NL'(bus.req_rdy), NL'(!eb));
            check("resident", bus.resident, m_res);
            check("err", NL'(bus.err), NL'(m_err));
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_we"}, bus.line_we, NL'(0));
        check({tag, "_vld"}, NL'(bus.line_we_vld), NL'(0));
        check({tag, "_idx"}, NL'(bus.line_we_idx), NL'(0));
        check({tag, "_res"}, bus.resident, NL'(0));
        check({tag, "_busy"}, NL'(bus.busy), NL'(0));
        check({tag, "_rdy"}, NL'(bus.req_rdy), NL'(1));
        check({tag, "_err"}, NL'(bus.err), NL'(0));
    endtask

    initial begin
        int acc;
        int acc2;
        int n;
        logic [NL-1:0] v;
        bus.req_vld = 1'b0;
        bus.req_op  = OP_NOP;
        bus.req_idx = '0;
        m_res = '0;
        m_err = 1'b0;

        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // single ALLOC 5, latency 2
        send(OP_ALLOC, 5, acc);
        idle(4);
        v = '0; v[5] = 1'b1;
        check("res_after_alloc5", bus.resident, v);

        // back-to-back: lines 0, 1023, 0
        send(OP_INVAL, 5, acc);
        send(OP_ALLOC, 0, acc);
        send(OP_ALLOC, 1023, acc);
        send(OP_INVAL, 0, acc);
        idle(4);
        v = '0; v[1023] = 1'b1;
        check("res_after_triple", bus.resident, v);

        // NOP slots around ALLOC 12
        send(OP_NOP, 12, acc);
        send(OP_ALLOC, 12, acc);
        send(OP_NOP, 0, acc);
        idle(4);

        // double ALLOC 9
        send(OP_ALLOC, 9, acc);
        send(OP_ALLOC, 9, acc);
        idle(4);
        check("err_after_dup", NL'(bus.err), NL'(CHK_EN));
        idle(3);
        check("err_sticky", NL'(bus.err), NL'(CHK_EN));

        // flush with {3,700} resident, ALLOC 44 held behind it
        send(OP_INVAL, 1023, acc);
        send(OP_INVAL, 12, acc);
        send(OP_INVAL, 9, acc);
        send(OP_ALLOC, 3, acc);
        send(OP_ALLOC, 700, acc);
        idle(4);
        v = '0; v[3] = 1'b1; v[700] = 1'b1;
        check("res_before_flush", bus.resident, v);
        busy_cnt = 0;
        send(OP_FLUSH, 0, acc);
        send(OP_ALLOC, 44, acc2);
        check("held_accept_edge", NL'(acc2), NL'(acc + 1027));
        check("busy_cycles", NL'(busy_cnt), NL'(1026));
        idle(4);

        // reset while sweeping line 300
        send(OP_FLUSH, 0, acc);
        bus.req_vld = 1'b0;
        n = 0;
        while (cyc < acc + 303 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("sweep_reached_300", NL'(bus.line_we_idx), NL'(300));
        rst = 1'b1;
        mon_en = 1'b0;
        #1;
        check_cleared("midreset");
        q.delete();
        m_res = '0;
        m_err = 1'b0;
        flush_edge = -1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        send(OP_ALLOC, 7, acc);
        idle(4);
        v = '0; v[7] = 1'b1;
        check("res_after_reset_alloc7", bus.resident, v);
        check("queue_drained", NL'(q.size()), NL'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
